// File: rtl/img_rotate_buf_pkg.sv
// -----------------------------------------------------------------------------
// img_rotate_buf_pkg
// Shared definitions for the frame rotation buffer:
//   - rotation codes ROT_0 / ROT_90 / ROT_180 / ROT_270 (clockwise)
//   - controller state enumeration
//   - is_transposed(): true for rotations that swap output width and height
// -----------------------------------------------------------------------------
package img_rotate_buf_pkg;

   localparam logic [1:0] ROT_0   = 2'd0;
   localparam logic [1:0] ROT_90  = 2'd1;
   localparam logic [1:0] ROT_180 = 2'd2;
   localparam logic [1:0] ROT_270 = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // 90 and 270 degree rotations produce an IMG_H wide x IMG_W high frame.
   function automatic logic is_transposed(input logic [1:0] r);
      return (r == ROT_90) || (r == ROT_270);
   endfunction

endpackage

// File: rtl/img_rotate_buf_ram.sv
// -----------------------------------------------------------------------------
// img_rot_ram
// Single-clock frame buffer: one write port, one read port, registered read.
// The read register only updates when rd_en is high, so its value holds while
// the consumer stalls. The storage array itself is never reset.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the read register only
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe, data appears on rd_data one cycle later
//   rd_addr  : read address
//   rd_data  : registered read data
// -----------------------------------------------------------------------------
module img_rot_ram #(
   parameter int PIX_W  = 24,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [PIX_W-1:0]  rd_data
);

   logic [PIX_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/img_rotate_buf.sv
// -----------------------------------------------------------------------------
// img_rotate_buf
// Buffers one row-major frame of IMG_W x IMG_H pixels and replays it rotated
// by 0/90/180/270 degrees clockwise. One frame is in flight at a time.
//
// Optional feature: define IMG_ROT_MIRROR_EN to add the 'mirror' input, which
// horizontally flips every output row after rotation. Without the macro the
// port is absent and the block behaves as if mirror were 0.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, aborts any frame
//   start      : one-cycle pulse, begins loading a frame (only in IDLE)
//   rot        : rotation code, sampled on an accepted start
//   mirror     : (IMG_ROT_MIRROR_EN only) row flip, sampled on accepted start
//   in_valid   : input pixel valid
//   in_data    : input pixel, row-major order
//   in_ready   : high while loading
//   out_valid  : out_data valid
//   out_data   : rotated pixel
//   out_ready  : downstream accept
//   line_end   : marks the last pixel of each output row
//   frame_done : marks the last pixel of the frame
//   busy       : high whenever not IDLE
// -----------------------------------------------------------------------------
module img_rotate_buf #(
   parameter int PIX_W = 24,
   parameter int IMG_W = 256,
   parameter int IMG_H = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       rot,
`ifdef IMG_ROT_MIRROR_EN
   input  logic             mirror,
`endif
   input  logic             in_valid,
   input  logic [PIX_W-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [PIX_W-1:0] out_data,
   input  logic             out_ready,
   output logic             line_end,
   output logic             frame_done,
   output logic             busy
);

   import img_rotate_buf_pkg::*;

   localparam int DEPTH   = IMG_W * IMG_H;
   localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DIM_MAX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
   localparam int CNT_W   = (DIM_MAX > 1) ? $clog2(DIM_MAX) : 1;

   // Address constants; negative steps rely on modulo-2^ADDR_W wrap.
   localparam logic [ADDR_W-1:0] A_ZERO = '0;
   localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_NEG1 = ADDR_W'(-1);
   localparam logic [ADDR_W-1:0] A_W    = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] A_NW   = ADDR_W'(-IMG_W);
   localparam logic [ADDR_W-1:0] A_W1   = ADDR_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] A_LASTROW = ADDR_W'((IMG_H - 1) * IMG_W);
   localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] A_LASTROW_END = ADDR_W'(DEPTH - IMG_W);

   state_t            state;
   logic [1:0]        rot_q;
   logic [ADDR_W-1:0] ld_addr;
   logic [ADDR_W-1:0] rd_addr_p0;
   logic [ADDR_W-1:0] row_base;
   logic [ADDR_W-1:0] col_step;
   logic [ADDR_W-1:0] row_step;
   logic [CNT_W-1:0]  col;
   logic [CNT_W-1:0]  row;
   logic [CNT_W-1:0]  w_last;
   logic [CNT_W-1:0]  h_last;
   logic              col_last;
   logic              row_last;
   logic              mir_req;
   logic              wr_en;
   logic              rd_en_p0;

`ifdef IMG_ROT_MIRROR_EN
   assign mir_req = mirror;
`else
   assign mir_req = 1'b0;
`endif

   always_comb begin
      w_last = is_transposed(rot_q) ? CNT_W'(IMG_H - 1) : CNT_W'(IMG_W - 1);
      h_last = is_transposed(rot_q) ? CNT_W'(IMG_W - 1) : CNT_W'(IMG_H - 1);
   end

   assign col_last = (col == w_last);
   assign row_last = (row == h_last);
   assign wr_en    = in_valid && in_ready;
   // Issue a read only when the output register is free or is being taken.
   assign rd_en_p0 = (state == READ) && (!out_valid || out_ready);

   // ---- stage p0: address issue / p1: registered RAM output is out_data ----
   img_rot_ram #(
      .PIX_W (PIX_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .wr_addr(ld_addr),
      .wr_data(in_data),
      .rd_en  (rd_en_p0),
      .rd_addr(rd_addr_p0),
      .rd_data(out_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rot_q      <= ROT_0;
         ld_addr    <= '0;
         rd_addr_p0 <= '0;
         row_base   <= '0;
         col_step   <= '0;
         row_step   <= '0;
         col        <= '0;
         row        <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         line_end   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         // Output flags travel with the read they describe.
         if (rd_en_p0) begin
            out_valid  <= 1'b1;
            line_end   <= col_last;
            frame_done <= col_last && row_last;
         end else if (out_ready) begin
            out_valid  <= 1'b0;
            line_end   <= 1'b0;
            frame_done <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  rot_q    <= rot;
                  ld_addr  <= '0;
                  col      <= '0;
                  row      <= '0;
                  // Start address is output (row 0, col 0); with mirror the
                  // walk starts at the far end of the row and runs backwards.
                  case (rot)
                     ROT_0: begin
                        row_base   <= mir_req ? A_W1 : A_ZERO;
                        rd_addr_p0 <= mir_req ? A_W1 : A_ZERO;
                        col_step   <= mir_req ? A_NEG1 : A_ONE;
                        row_step   <= A_W;
                     end
                     ROT_90: begin
                        row_base   <= mir_req ? A_ZERO : A_LASTROW;
                        rd_addr_p0 <= mir_req ? A_ZERO : A_LASTROW;
                        col_step   <= mir_req ? A_W : A_NW;
                        row_step   <= A_ONE;
                     end
                     ROT_180: begin
                        row_base   <= mir_req ? A_LASTROW_END : A_LAST;
                        rd_addr_p0 <= mir_req ? A_LASTROW_END : A_LAST;
                        col_step   <= mir_req ? A_ONE : A_NEG1;
                        row_step   <= A_NW;
                     end
                     default: begin
                        row_base   <= mir_req ? A_LAST : A_W1;
                        rd_addr_p0 <= mir_req ? A_LAST : A_W1;
                        col_step   <= mir_req ? A_NW : A_W;
                        row_step   <= A_NEG1;
                     end
                  endcase
               end
            end

            LOAD: begin
               if (wr_en) begin
                  ld_addr <= ld_addr + A_ONE;
                  if (ld_addr == A_LAST) begin
                     state    <= READ;
                     in_ready <= 1'b0;
                  end
               end
            end

            READ: begin
               if (rd_en_p0) begin
                  if (col_last) begin
                     col        <= '0;
                     row        <= row + CNT_W'(1);
                     row_base   <= row_base + row_step;
                     rd_addr_p0 <= row_base + row_step;
                     if (row_last) begin
                        state <= DRAIN;
                     end
                  end else begin
                     col        <= col + CNT_W'(1);
                     rd_addr_p0 <= rd_addr_p0 + col_step;
                  end
               end
            end

            DRAIN: begin
               if (out_valid && out_ready) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_img_rotate_buf.sv
module tb_img_rotate_buf;

   localparam int PIX_W = 24;
   localparam int IMG_W = 4;
   localparam int IMG_H = 3;
   localparam int NPIX  = IMG_W * IMG_H;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [1:0]       rot;
`ifdef IMG_ROT_MIRROR_EN
   logic             mirror;
`endif
   logic             in_valid;
   logic [PIX_W-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [PIX_W-1:0] out_data;
   logic             out_ready;
   logic             line_end;
   logic             frame_done;
   logic             busy;

   always #5 clk = ~clk;

   img_rotate_buf #(
      .PIX_W(PIX_W),
      .IMG_W(IMG_W),
      .IMG_H(IMG_H)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rot       (rot),
`ifdef IMG_ROT_MIRROR_EN
      .mirror    (mirror),
`endif
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .line_end  (line_end),
      .frame_done(frame_done),
      .busy      (busy)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] r;
      bit         mir;
      int         mode;    // 0: out_ready always 1, 1: pattern 1,0,0,1
      int         w;       // output row width
      bit         inject;  // pulse a second start while reading
      int         e [NPIX];
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic start_pulse(input logic [1:0] r, input bit m);
      start = 1'b1;
      rot   = r;
`ifdef IMG_ROT_MIRROR_EN
      mirror = m;
`else
      if (m) $display("note: mirror requested without IMG_ROT_MIRROR_EN");
`endif
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic load_frame(input int base, input int nbeats);
      int  idx = 0;
      int  g   = 0;
      bit  acc;
      while (idx < nbeats && g < 100) begin
         in_valid = 1'b1;
         in_data  = PIX_W'(base + idx);
         acc      = in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         g++;
      end
      in_valid = 1'b0;
      chk("load_beats", idx, nbeats);
   endtask

   task automatic drain_frame(input vec_t v, input string tag);
      int               n    = 0;
      int               cyc  = 0;
      bit               held = 1'b0;
      logic [PIX_W-1:0] hd;
      logic             hle;
      logic             hfd;
      int               extra = 0;
      while (n < NPIX && cyc < 400) begin
         out_ready = (v.mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         start     = v.inject && (cyc == 2);
         if (v.inject && cyc == 2) rot = 2'd3;
         if (held) begin
            chk($sformatf("%s hold_valid", tag), out_valid, 1);
            chk($sformatf("%s hold_data", tag), out_data, hd);
            chk($sformatf("%s hold_le", tag), line_end, hle);
            chk($sformatf("%s hold_fd", tag), frame_done, hfd);
         end
         held = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               chk($sformatf("%s data[%0d]", tag, n), out_data, v.e[n]);
               chk($sformatf("%s line_end[%0d]", tag, n), line_end, (n % v.w) == (v.w - 1));
               chk($sformatf("%s frame_done[%0d]", tag, n), frame_done, n == NPIX - 1);
               n++;
            end else begin
               held = 1'b1;
               hd   = out_data;
               hle  = line_end;
               hfd  = frame_done;
            end
         end
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      out_ready = 1'b1;
      chk($sformatf("%s frame_beats", tag), n, NPIX);
      chk($sformatf("%s busy_after", tag), busy, 0);
      for (int i = 0; i < 3; i++) begin
         if (out_valid) extra++;
         @(posedge clk); #1;
      end
      chk($sformatf("%s extra_beats", tag), extra, 0);
   endtask

   initial begin
      vecs[0] = '{r: 2'd0, mir: 1'b0, mode: 0, w: 4, inject: 1'b0,
                  e: '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11}};
      vecs[1] = '{r: 2'd1, mir: 1'b0, mode: 0, w: 3, inject: 1'b0,
                  e: '{8, 4, 0, 9, 5, 1, 10, 6, 2, 11, 7, 3}};
      vecs[2] = '{r: 2'd2, mir: 1'b0, mode: 0, w: 4, inject: 1'b0,
                  e: '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0}};
      vecs[3] = '{r: 2'd3, mir: 1'b0, mode: 0, w: 3, inject: 1'b0,
                  e: '{3, 7, 11, 2, 6, 10, 1, 5, 9, 0, 4, 8}};
      vecs[4] = '{r: 2'd1, mir: 1'b0, mode: 1, w: 3, inject: 1'b0,
                  e: '{8, 4, 0, 9, 5, 1, 10, 6, 2, 11, 7, 3}};
      vecs[5] = '{r: 2'd0, mir: 1'b0, mode: 0, w: 4, inject: 1'b1,
                  e: '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11}};
      vecs[6] = '{r: 2'd0, mir: 1'b1, mode: 0, w: 4, inject: 1'b0,
                  e: '{3, 2, 1, 0, 7, 6, 5, 4, 11, 10, 9, 8}};

      rst       = 1'b1;
      start     = 1'b0;
      rot       = 2'd0;
`ifdef IMG_ROT_MIRROR_EN
      mirror    = 1'b0;
`endif
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      chk("rst line_end", line_end, 0);
      chk("rst frame_done", frame_done, 0);
      chk("rst busy", busy, 0);
      rst = 1'b0;

      // in_valid while idle must not start anything
      in_valid = 1'b1;
      in_data  = PIX_W'(999);
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("idle in_ready", in_ready, 0);
      chk("idle busy", busy, 0);

      // table-driven frames
      for (int k = 0; k < 5; k++) begin
         start_pulse(vecs[k].r, vecs[k].mir);
         chk($sformatf("vec%0d busy_load", k), busy, 1);
         load_frame(0, NPIX);
         drain_frame(vecs[k], $sformatf("vec%0d", k));
      end

      // reset after 5 load beats, then a fresh rot=0 frame with a
      // second start pulsed while it is being read out
      start_pulse(2'd2, 1'b0);
      load_frame(50, 5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort in_ready", in_ready, 0);
      chk("abort out_valid", out_valid, 0);
      begin
         int stale = 0;
         for (int i = 0; i < 6; i++) begin
            if (out_valid || in_ready) stale++;
            @(posedge clk); #1;
         end
         chk("abort no_stale", stale, 0);
      end
      start_pulse(vecs[5].r, vecs[5].mir);
      load_frame(0, NPIX);
      drain_frame(vecs[5], "restart");

`ifdef IMG_ROT_MIRROR_EN
      start_pulse(vecs[6].r, vecs[6].mir);
      load_frame(0, NPIX);
      drain_frame(vecs[6], "mirror");
      mirror = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
